// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state constants for the sequenced ALU and its bench.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath: everything except MUL, which the sequencer owns.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit holds carry-out for ADD and the borrow for SUB (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; MUL yields zeros here since its result comes from the sequencer.
  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_SUB: begin
        y     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASS: y = a;
      OP_MUL:  y = '0;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle ops through alu_seq_comb, MUL as a WIDTH-step shift-add.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; single-cycle ops complete on the accepting edge
// MUL     | shift-add in progress, one multiplier bit per cycle, busy=1
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   comb_y;
  logic               comb_carry;
  logic [2*WIDTH-1:0] prod_step;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .op    (op),
    .a     (a),
    .b     (b),
    .y     (comb_y),
    .carry (comb_carry)
  );

  // Partial product after consuming the current low multiplier bit.
  assign prod_step = mplr_q[0] ? (prod_q + mcand_q) : prod_q;

  // Next-state, datapath and result-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    y_d     = y_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            // Operands are captured here so later input changes cannot disturb the product.
            state_d = ST_MUL;
            cnt_d   = '0;
            prod_d  = '0;
            mcand_d = {{WIDTH{1'b0}}, a};
            mplr_d  = b;
          end else begin
            y_d     = comb_y;
            carry_d = comb_carry;
            zero_d  = (comb_y == '0);
            done_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        prod_d  = prod_step;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          y_d     = prod_step[WIDTH-1:0];
          carry_d = |prod_step[2*WIDTH-1:WIDTH];
          zero_d  = (prod_step[WIDTH-1:0] == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset wins over any start or MUL in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign y     = y_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign done  = done_q;
  assign busy  = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4) against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         carry;
  logic         zero;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .y     (y),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: the result rules expressed as plain integer arithmetic.
  function automatic void ref_alu(input logic [2:0] o, input int x, input int z,
                                  output int ry, output logic rc);
    int r;
    r  = 0;
    rc = 1'b0;
    case (o)
      OP_ADD:  begin r = x + z; rc = (r >= MOD); end
      OP_SUB:  begin r = x - z + MOD; rc = (x < z); end
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_XOR:  r = x ^ z;
      OP_SLT:  r = (x < z) ? 1 : 0;
      OP_MUL:  begin r = x * z; rc = (r >= MOD); end
      default: r = x;
    endcase
    ry = r % MOD;
  endfunction

  // Present a start for exactly one edge; returns just after that edge.
  task automatic drive_start(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    @(negedge clk);
    op = o; a = x; b = z; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; op = OP_ADD; a = 4'd2; b = 4'd4;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({y, carry, zero, busy, done} !== 8'b0) begin
      n_errors++;
      $display("FAIL reset_state: got y=%b c=%b z=%b busy=%b done=%b, expected all 0", y, carry, zero, busy, done);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({y, done, busy} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_start_discard: got y=%b done=%b busy=%b, expected 0 0 0", y, done, busy);
    end
  endtask

  task automatic test_single;
    logic [16:0] tbl [3];
    logic [2:0]  o;
    logic [3:0]  x, z, ey;
    logic        ec, ez;
    tbl[0] = {OP_ADD, 4'd2, 4'd4, 4'b0110, 1'b0, 1'b0};
    tbl[1] = {OP_ADD, 4'd8, 4'd8, 4'b0000, 1'b1, 1'b1};
    tbl[2] = {OP_SUB, 4'd4, 4'd5, 4'b1111, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      {o, x, z, ey, ec, ez} = tbl[i];
      drive_start(o, x, z);
      n_checks++;
      if ({y, carry, zero, done, busy} !== {ey, ec, ez, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL single_%0d: got y=%b c=%b z=%b done=%b busy=%b, expected y=%b c=%b z=%b done=1 busy=0",
                 i, y, carry, zero, done, busy, ey, ec, ez);
      end
      // Inputs wander while idle; the result must hold and done must drop.
      @(negedge clk);
      a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({y, carry, zero, done} !== {ey, ec, ez, 1'b0}) begin
        n_errors++;
        $display("FAIL hold_%0d: got y=%b c=%b z=%b done=%b, expected y=%b c=%b z=%b done=0",
                 i, y, carry, zero, done, ey, ec, ez);
      end
    end
  endtask

  task automatic test_mul;
    logic [W-1:0] x, z;
    int ey, cyc, spurious;
    logic ec;
    for (int i = 0; i < 22; i++) begin
      if (i == 0) begin x = 4'd3; z = 4'd5; end
      else if (i == 1) begin x = 4'd4; z = 4'd4; end
      else begin x = 4'($urandom); z = 4'($urandom); end
      ref_alu(OP_MUL, int'(x), int'(z), ey, ec);
      drive_start(OP_MUL, x, z);
      cyc = 0; spurious = 0;
      while (busy === 1'b1 && cyc < 20) begin
        if (done !== 1'b0) spurious++;
        cyc++;
        a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
        @(posedge clk); #1;
      end
      n_checks++;
      if (cyc != W || spurious != 0) begin
        n_errors++;
        $display("FAIL mul_busy_%0d: got busy cycles=%0d early dones=%0d, expected %0d and 0", i, cyc, spurious, W);
      end
      n_checks++;
      if ({y, carry, zero, done} !== {4'(ey), ec, (ey == 0), 1'b1}) begin
        n_errors++;
        $display("FAIL mul_%0d (%0d*%0d): got y=%b c=%b z=%b done=%b, expected y=%b c=%b z=%b done=1",
                 i, x, z, y, carry, zero, done, 4'(ey), ec, (ey == 0));
      end
    end
  endtask

  task automatic test_mul_ignore_start;
    int ndone;
    logic [W-1:0] yd;
    drive_start(OP_MUL, 4'd3, 4'd5);
    ndone = 0; yd = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 2) begin op = OP_ADD; a = 4'd1; b = 4'd1; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin ndone++; yd = y; end
    end
    n_checks++;
    if (ndone != 1 || yd !== 4'd15 || y !== 4'd15) begin
      n_errors++;
      $display("FAIL mul_ignore_start: got dones=%0d y_at_done=%0d y_end=%0d, expected 1 15 15", ndone, yd, y);
    end
  endtask

  task automatic test_reset_mid_mul;
    int ndone;
    drive_start(OP_ADD, 4'd2, 4'd4);
    drive_start(OP_MUL, 4'd3, 4'd5);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({y, carry, zero, busy, done} !== 8'b0) begin
      n_errors++;
      $display("FAIL reset_mid_mul: got y=%b c=%b z=%b busy=%b done=%b, expected all 0", y, carry, zero, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || y !== 4'd0) ndone++;
    end
    n_checks++;
    if (ndone != 0) begin
      n_errors++;
      $display("FAIL aborted_mul_quiet: got %0d cycles with done/busy/y activity, expected 0", ndone);
    end
    drive_start(OP_ADD, 4'd2, 4'd4);
    n_checks++;
    if ({y, done} !== {4'b0110, 1'b1}) begin
      n_errors++;
      $display("FAIL add_after_reset: got y=%b done=%b, expected y=0110 done=1", y, done);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]   ops [3];
    logic [W-1:0] xs [3];
    logic [W-1:0] zs [3];
    logic [W-1:0] es [3];
    ops[0] = OP_SLT;  xs[0] = 4'd3;     zs[0] = 4'd5;     es[0] = 4'b0001;
    ops[1] = OP_XOR;  xs[1] = 4'b1010;  zs[1] = 4'b0110;  es[1] = 4'b1100;
    ops[2] = OP_PASS; xs[2] = 4'b0111;  zs[2] = 4'($urandom); es[2] = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op = ops[i]; a = xs[i]; b = zs[i]; start = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({y, carry, done, busy} !== {es[i], 1'b0, 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL b2b_%0d: got y=%b c=%b done=%b busy=%b, expected y=%b c=0 done=1 busy=0",
                 i, y, carry, done, busy, es[i]);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({y, done} !== {4'b0111, 1'b0}) begin
      n_errors++;
      $display("FAIL b2b_end: got y=%b done=%b, expected y=0111 done=0", y, done);
    end
  endtask

  task automatic test_random;
    logic [2:0]   o;
    logic [W-1:0] x, z;
    int ey, cyc;
    logic ec;
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom); x = 4'($urandom); z = 4'($urandom);
      ref_alu(o, int'(x), int'(z), ey, ec);
      drive_start(o, x, z);
      cyc = 0;
      while (busy === 1'b1 && cyc < 20) begin
        cyc++;
        a = 4'($urandom); b = 4'($urandom); op = 3'($urandom);
        @(posedge clk); #1;
      end
      n_checks++;
      if ({y, carry, zero, done, busy} !== {4'(ey), ec, (ey == 0), 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL rand_%0d op=%b a=%0d b=%0d: got y=%b c=%b z=%b done=%b busy=%b, expected y=%b c=%b z=%b done=1 busy=0",
                 i, o, x, z, y, carry, zero, done, busy, 4'(ey), ec, (ey == 0));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0;
    test_reset;
    test_single;
    test_mul;
    test_mul_ignore_start;
    test_reset_mid_mul;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand/result width in bits (legal 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin an operation.
REQ-005 The block SHALL have port op, input, 3, the opcode.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, the unsigned operands.
REQ-007 The block SHALL have port y, output, WIDTH, the registered result.
REQ-008 The block SHALL have ports carry and zero, output, 1 each, the registered result flags.
REQ-009 The block SHALL have port busy, output, 1, high while a multi-cycle operation runs.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse marking a new y/flags value.

Function
REQ-011 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (unsigned, y=1 if a<b else 0), 110 MUL, 111 PASS (y=a).
REQ-012 start SHALL be accepted only on an edge where state is IDLE; start while busy=1 is ignored and leaves no pending request.
REQ-013 a, b and op SHALL be captured at the accepting edge; later changes to them do not affect the operation.
REQ-014 Single-cycle ops (all except MUL) SHALL load y, carry and zero at the accepting edge and assert done for the following cycle; busy stays 0.
REQ-015 MUL SHALL be a shift-add over WIDTH iterations: state MUL, busy=1 for exactly WIDTH cycles, y/flags loaded and done asserted at the edge ending the WIDTH-th cycle, then IDLE.
REQ-016 The state machine SHALL have states IDLE and MUL only; IDLE->MUL on accepted MUL start, MUL->IDLE when the iteration counter reaches WIDTH-1.
REQ-017 ADD carry SHALL be the carry-out of a+b; SUB y SHALL be a-b modulo 2^WIDTH with carry=1 on borrow (a<b).
REQ-018 MUL y SHALL be the low WIDTH bits of the 2*WIDTH product; carry SHALL be 1 if the high WIDTH bits are non-zero.
REQ-019 AND, OR, XOR, SLT and PASS SHALL drive carry=0.
REQ-020 zero SHALL be 1 exactly when the newly loaded y equals 0.
REQ-021 y, carry and zero SHALL hold their last value until the next result load.
REQ-022 A start on the cycle done is high (busy=0) SHALL be accepted, giving back-to-back results at one per cycle for single-cycle ops.

Reset
REQ-023 While reset is high at an edge: state=IDLE, y=0, carry=0, zero=0, busy=0, done=0, iteration counter and internal product cleared.
REQ-024 Reset SHALL take priority over start, including mid-MUL; the aborted MUL produces no done pulse and no y update.
REQ-025 start asserted together with reset SHALL be discarded.

Structure
REQ-026 Opcode constants and the state encoding SHALL live in shared package alu_seq_pkg, reused by the bench.
REQ-027 The single-cycle datapath (REQ-011, 017, 019) SHALL be a combinational sub-module alu_seq_comb, parametrised by WIDTH; alu_seq holds the FSM, MUL datapath and output registers.

Verification (WIDTH=4)
REQ-028 ADD a=2,b=4 -> next cycle y=0110, carry=0, zero=0, done=1 for one cycle, busy=0.
REQ-029 ADD a=8,b=8 -> y=0000, carry=1, zero=1; SUB a=4,b=5 -> y=1111, carry=1, zero=0.
REQ-030 MUL a=3,b=5 -> busy=1 for 4 cycles, then y=1111, carry=0, done=1; MUL a=4,b=4 -> y=0000, carry=1, zero=1.
REQ-031 MUL a=3,b=5 then start with ADD 1+1 during busy -> ADD ignored; only MUL result (15) appears, single done pulse.
REQ-032 reset asserted in 2nd MUL cycle -> next cycle all outputs 0, state IDLE, no done; a following ADD 2+4 gives y=0110.
REQ-033 Back-to-back start every cycle with SLT 3<5, XOR 1010^0110, PASS 0111 -> y=0001, 1100, 0111 on consecutive cycles, done held high 3 cycles.
